bus_cycle_ctrl: RTL and testbench

Synchronous 68000 bus-cycle controller for the memory/I-O decode CPLD. It watches /AS and the active-low region selects from `mem_decoder` (RAM, ROM, DUART) and inserts per-region wait states. It generates /DTACK for each cycle and, when enabled, raises /BERR on a watchdog timeout so the CPU never hangs on an unmapped address.

---
 rtl/bus_cycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bus_cycle_ctrl
// Brief    : 68000 bus-cycle controller. Per-region wait states, /DTACK
//            generation and an optional /BERR watchdog built when the
//            BERR_TIMEOUT_EN macro is defined.
// Revision : 1.0
// ============================================================================
module bus_cycle_ctrl #(
    parameter int unsigned RAM_WS  = 0,
    parameter int unsigned ROM_WS  = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic as,
    input  logic ram_cs,
    input  logic rom_cs,
    input  logic duart_cs,
    input  logic duart_dtack,
    output logic dtack,
    output logic berr,
    output logic busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ACK   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RG_NONE  = 2'd0,
        RG_RAM   = 2'd1,
        RG_ROM   = 2'd2,
        RG_DUART = 2'd3
    } region_t;

    localparam logic [3:0] c_ram_ws = 4'(RAM_WS);
    localparam logic [3:0] c_rom_ws = 4'(ROM_WS);

    state_t     r_state;
    state_t     w_state_nxt;
    region_t    r_region;
    region_t    w_region_nxt;
    logic [3:0] r_ws_cnt;
    logic [3:0] w_ws_nxt;
    logic       r_duart_seen;
    logic       r_dtack;
    logic       w_ack;

`ifdef BERR_TIMEOUT_EN
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

    logic [7:0] r_tmo_cnt;
    logic [7:0] w_tmo_nxt;
    logic       w_timeout;
    logic       r_berr;

    assign w_timeout = (r_tmo_cnt >= c_tmo_last);
`endif

    // Acknowledge source for the region latched at the start of the cycle.
    always_comb begin
        w_ack = 1'b0;
        case (r_region)
            RG_RAM, RG_ROM: w_ack = (r_ws_cnt == 4'd0);
            RG_DUART:       w_ack = r_duart_seen;
            default:        w_ack = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_region_nxt = r_region;
        w_ws_nxt     = r_ws_cnt;
`ifdef BERR_TIMEOUT_EN
        w_tmo_nxt    = r_tmo_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!as) begin
                    w_state_nxt = ST_WAIT;
`ifdef BERR_TIMEOUT_EN
                    w_tmo_nxt   = 8'd0;
`endif
                    if (!ram_cs) begin
                        w_region_nxt = RG_RAM;
                        w_ws_nxt     = c_ram_ws;
                    end else if (!rom_cs) begin
                        w_region_nxt = RG_ROM;
                        w_ws_nxt     = c_rom_ws;
                    end else if (!duart_cs) begin
                        w_region_nxt = RG_DUART;
                        w_ws_nxt     = 4'd0;
                    end else begin
                        w_region_nxt = RG_NONE;
                        w_ws_nxt     = 4'd0;
                    end
                end
            end
            ST_WAIT: begin
                // Abort beats ack, ack beats timeout.
                if (as) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_ack) begin
                    w_state_nxt = ST_ACK;
`ifdef BERR_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_state_nxt = ST_FAULT;
`endif
                end
                if (r_ws_cnt != 4'd0) begin
                    w_ws_nxt = r_ws_cnt - 4'd1;
                end
`ifdef BERR_TIMEOUT_EN
                if (r_tmo_cnt != 8'hFF) begin
                    w_tmo_nxt = r_tmo_cnt + 8'd1;
                end
`endif
            end
            ST_ACK: begin
                if (as) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef BERR_TIMEOUT_EN
            ST_FAULT: begin
                if (as) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_region     <= RG_NONE;
            r_ws_cnt     <= 4'd0;
            r_duart_seen <= 1'b0;
            r_dtack      <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_region     <= w_region_nxt;
            r_ws_cnt     <= w_ws_nxt;
            // DUART ack is only looked at once it has been sampled inside WAIT.
            r_duart_seen <= (r_state == ST_WAIT) && !duart_dtack;
            r_dtack      <= (w_state_nxt != ST_ACK);
        end
    end

`ifdef BERR_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= 8'd0;
            r_berr    <= 1'b1;
        end else begin
            r_tmo_cnt <= w_tmo_nxt;
            r_berr    <= (w_state_nxt != ST_FAULT);
        end
    end

    assign berr = r_berr;
`else
    assign berr = 1'b1;
`endif

    assign dtack = r_dtack;
    assign busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_cycle_ctrl
// Brief    : Directed bench for bus_cycle_ctrl (default and TIMEOUT=3 builds)
//            checked against a cycle-level behavioural model.
// Revision : 1.0
// ============================================================================
module tb_bus_cycle_ctrl;

    localparam int c_ram_ws = 0;
    localparam int c_rom_ws = 2;
    localparam int c_tmo0   = 64;
    localparam int c_tmo1   = 3;
`ifdef BERR_TIMEOUT_EN
    localparam bit c_berr_en = 1'b1;
`else
    localparam bit c_berr_en = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, as, ram_cs, rom_cs, duart_cs, duart_dtack;
    logic dtack0, berr0, busy0;
    logic dtack1, berr1, busy1;

    always #5 clk = ~clk;

    bus_cycle_ctrl #(.RAM_WS(c_ram_ws), .ROM_WS(c_rom_ws), .TIMEOUT(c_tmo0)) dut0 (
        .clk(clk), .reset(reset), .as(as), .ram_cs(ram_cs), .rom_cs(rom_cs),
        .duart_cs(duart_cs), .duart_dtack(duart_dtack),
        .dtack(dtack0), .berr(berr0), .busy(busy0)
    );

    bus_cycle_ctrl #(.RAM_WS(c_ram_ws), .ROM_WS(c_rom_ws), .TIMEOUT(c_tmo1)) dut1 (
        .clk(clk), .reset(reset), .as(as), .ram_cs(ram_cs), .rom_cs(rom_cs),
        .duart_cs(duart_cs), .duart_dtack(duart_dtack),
        .dtack(dtack1), .berr(berr1), .busy(busy1)
    );

    // Cycle-level model: k counts edges since the cycle started, res is
    // 0 pending / 1 acknowledged / 2 bus error, dl = DUART ack seen last edge.
    typedef struct {
        bit act;
        int res;
        int k;
        int region;
        bit dl;
    } mstate_t;

    mstate_t m0, m1;

    function automatic bit acked(int region, int k, bit dl);
        case (region)
            1:       return k >= c_ram_ws + 1;
            2:       return k >= c_rom_ws + 1;
            3:       return dl;
            default: return 1'b0;
        endcase
    endfunction

    function automatic mstate_t step(mstate_t s, int tmo, logic a, logic rc,
                                     logic oc, logic dc, logic dd);
        mstate_t n = s;
        if (!s.act) begin
            if (!a) begin
                n.act    = 1'b1;
                n.res    = 0;
                n.k      = 0;
                n.dl     = 1'b0;
                n.region = !rc ? 1 : (!oc ? 2 : (!dc ? 3 : 0));
            end
        end else if (s.res == 0) begin
            n.k = s.k + 1;
            if (a)                              n.act = 1'b0;
            else if (acked(s.region, n.k, s.dl)) n.res = 1;
            else if (c_berr_en && n.k >= tmo)   n.res = 2;
            n.dl = (s.region == 3) && !dd;
        end else if (a) begin
            n.act = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m0 <= '{1'b0, 0, 0, 0, 1'b0};
            m1 <= '{1'b0, 0, 0, 0, 1'b0};
        end else begin
            m0 <= step(m0, c_tmo0, as, ram_cs, rom_cs, duart_cs, duart_dtack);
            m1 <= step(m1, c_tmo1, as, ram_cs, rom_cs, duart_cs, duart_dtack);
        end
    end

    // Hand-computed expectations posted by the stimulus for the next negedge.
    logic  lit_en = 1'b0;
    int    lit_sel;
    logic  lit_d, lit_b, lit_bz;
    string lit_nm;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string nm, logic got, logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", nm, $time, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("model0_dtack", dtack0, !(m0.act && m0.res == 1));
            chk("model0_berr",  berr0,  !(m0.act && m0.res == 2));
            chk("model0_busy",  busy0,  m0.act);
            chk("model1_dtack", dtack1, !(m1.act && m1.res == 1));
            chk("model1_berr",  berr1,  !(m1.act && m1.res == 2));
            chk("model1_busy",  busy1,  m1.act);
            if (lit_en) begin
                chk({lit_nm, "_dtack"}, (lit_sel == 0) ? dtack0 : dtack1, lit_d);
                chk({lit_nm, "_berr"},  (lit_sel == 0) ? berr0  : berr1,  lit_b);
                chk({lit_nm, "_busy"},  (lit_sel == 0) ? busy0  : busy1,  lit_bz);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        lit_en = 1'b0;
    endtask

    task automatic lit(int sel, logic d, logic b, logic bz, string nm);
        lit_sel = sel;
        lit_d   = d;
        lit_b   = b;
        lit_bz  = bz;
        lit_nm  = nm;
        lit_en  = 1'b1;
    endtask

    task automatic idle_bus();
        as          = 1'b1;
        ram_cs      = 1'b1;
        rom_cs      = 1'b1;
        duart_cs    = 1'b1;
        duart_dtack = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        idle_bus();
        #1 reset = 1'b1;
        tick(); tick();
        lit(0, 1'b1, 1'b1, 1'b0, "reset_state");
        tick();
        reset = 1'b0;
        tick();

        // RAM read, zero wait states.
        as = 1'b0; ram_cs = 1'b0;
        tick(); lit(0, 1'b1, 1'b1, 1'b1, "ram_edge_n");
        tick(); lit(0, 1'b0, 1'b1, 1'b1, "ram_ack_n1");
        tick(); idle_bus();
        tick(); lit(0, 1'b1, 1'b1, 1'b0, "ram_release");

        // ROM read with a select change mid-WAIT that must be ignored.
        as = 1'b0; rom_cs = 1'b0;
        tick(); lit(0, 1'b1, 1'b1, 1'b1, "rom_edge_n");
        tick(); lit(0, 1'b1, 1'b1, 1'b1, "rom_n1");
        rom_cs = 1'b1; ram_cs = 1'b0;
        tick(); lit(0, 1'b1, 1'b1, 1'b1, "rom_n2");
        tick(); lit(0, 1'b0, 1'b1, 1'b1, "rom_ack_n3");
        tick(); idle_bus();
        tick(); lit(0, 1'b1, 1'b1, 1'b0, "rom_release");

        // ROM cycle aborted after one clock.
        as = 1'b0; rom_cs = 1'b0;
        tick(); idle_bus();
        tick(); lit(0, 1'b1, 1'b1, 1'b0, "rom_abort");
        tick(); tick();

        // DUART ack sampled at N+5, DUART-region timeout on the TIMEOUT=3 copy.
        as = 1'b0; duart_cs = 1'b0;
        tick();
        tick(); tick();
        tick(); lit(1, 1'b1, !c_berr_en, 1'b1, "t3_duart_timeout");
        tick(); duart_dtack = 1'b0; lit(0, 1'b1, 1'b1, 1'b1, "duart_n4");
        tick(); lit(0, 1'b1, 1'b1, 1'b1, "duart_n5");
        tick(); lit(0, 1'b0, 1'b1, 1'b1, "duart_ack_n6");
        tick(); tick();
        tick(); lit(0, 1'b0, 1'b1, 1'b1, "duart_hold");
        idle_bus();
        tick(); lit(0, 1'b1, 1'b1, 1'b0, "duart_release");

        // Unmapped address.
        as = 1'b0;
        tick();
        for (int k = 1; k < c_tmo0; k++) begin
            tick();
        end
        lit(0, 1'b1, 1'b1, 1'b1, "unmapped_n63");
        tick(); lit(0, 1'b1, !c_berr_en, 1'b1, "unmapped_n64");
        tick(); tick(); tick();
        idle_bus();
        tick(); lit(0, 1'b1, 1'b1, 1'b0, "unmapped_release");

        // TIMEOUT=3: DUART ack lands on the timeout edge, ack must win.
        as = 1'b0; duart_cs = 1'b0;
        tick();
        tick(); duart_dtack = 1'b0;
        tick();
        tick(); lit(1, 1'b0, 1'b1, 1'b1, "t3_ack_wins");
        idle_bus();
        tick(); lit(1, 1'b1, 1'b1, 1'b0, "t3_release");

        // Reset during ACK, then restart with /AS still low.
        as = 1'b0; ram_cs = 1'b0;
        tick();
        tick();
        #1 reset = 1'b1;
        lit(0, 1'b1, 1'b1, 1'b0, "reset_in_ack");
        tick();
        reset = 1'b0;
        tick(); lit(0, 1'b1, 1'b1, 1'b1, "restart_edge");
        tick(); lit(0, 1'b0, 1'b1, 1'b1, "restart_ack");
        idle_bus();
        tick(); lit(0, 1'b1, 1'b1, 1'b0, "restart_release");
        tick(); tick();

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
